// File: rtl/truth_table_sweeper_pkg.sv
// Shared FSM encodings and row-count helper for the truth-table sweeper.
// Pure declarations: no latency, no flow control.
package truth_table_sweeper_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic int rowsOf(input int nVars);
        return 1 << nVars;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control, mask and row-stream bundle of the sweeper; master drives start/masks.
// No backpressure: the row stream is push-only, one row per clock.
interface truth_table_sweeper_if
    import truth_table_sweeper_pkg::*;
#(
    parameter int N_VARS = 4
) ();

    localparam int ROWS = rowsOf(N_VARS);

    logic              start;
    logic              stop_on_mis;
    logic [ROWS-1:0]   mask_sop;
    logic [ROWS-1:0]   mask_pos;
    logic              busy;
    logic              row_valid;
    logic [N_VARS-1:0] row_idx;
    logic              row_sop;
    logic              row_pos;
    logic              row_match;
    logic              done;
    logic [N_VARS:0]   mis_cnt;
    logic              first_mis_valid;
    logic [N_VARS-1:0] first_mis_idx;

    modport master (
        output start, stop_on_mis, mask_sop, mask_pos,
        input  busy, row_valid, row_idx, row_sop, row_pos, row_match,
        input  done, mis_cnt, first_mis_valid, first_mis_idx
    );

    modport slave (
        input  start, stop_on_mis, mask_sop, mask_pos,
        output busy, row_valid, row_idx, row_sop, row_pos, row_match,
        output done, mis_cnt, first_mis_valid, first_mis_idx
    );

endinterface

// File: rtl/truth_table_sweeper_term_eval.sv
// Evaluates one truth-table row from SOP minterm and POS maxterm masks.
// Purely combinational (zero latency); no flow control.
module truth_table_sweeper_term_eval
    import truth_table_sweeper_pkg::*;
#(
    parameter  int N_VARS = 4,
    localparam int ROWS   = rowsOf(N_VARS)
) (
    input  logic [ROWS-1:0]   mask_sop,
    input  logic [ROWS-1:0]   mask_pos,
    input  logic [N_VARS-1:0] idx,
    output logic              sop,
    output logic              pos,
    output logic              match
);

    // A set maxterm bit forces the function to 0 on that row.
    assign sop   = mask_sop[idx];
    assign pos   = ~mask_pos[idx];
    assign match = (sop == pos);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all rows of an N-variable function, streaming SOP/POS evaluations and mismatch stats.
// Row k appears k+1 cycles after the start edge; no backpressure, start is sampled only in IDLE.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int N_VARS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    truth_table_sweeper_if.slave bus
);

    localparam int                ROWS     = rowsOf(N_VARS);
    localparam int                CNT_W    = N_VARS + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(ROWS);
    localparam logic [N_VARS-1:0] LAST_IDX = N_VARS'(ROWS - 1);
    localparam logic [N_VARS-1:0] IDX_ONE  = N_VARS'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic [1:0]        state;
    logic [ROWS-1:0]   maskSop;
    logic [ROWS-1:0]   maskPos;
    logic              stopOnMis;
    logic [N_VARS-1:0] idx;

    logic              evalSop;
    logic              evalPos;
    logic              evalMatch;

    logic              rowValid;
    logic [N_VARS-1:0] rowIdx;
    logic              rowSop;
    logic              rowPos;
    logic              rowMatch;
    logic              doneReg;
    logic [CNT_W-1:0]  misCnt;
    logic              firstMisValid;
    logic [N_VARS-1:0] firstMisIdx;

    truth_table_sweeper_term_eval #(
        .N_VARS (N_VARS)
    ) u_term_eval (
        .mask_sop (maskSop),
        .mask_pos (maskPos),
        .idx      (idx),
        .sop      (evalSop),
        .pos      (evalPos),
        .match    (evalMatch)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            maskSop       <= '0;
            maskPos       <= '0;
            stopOnMis     <= 1'b0;
            idx           <= '0;
            rowValid      <= 1'b0;
            rowIdx        <= '0;
            rowSop        <= 1'b0;
            rowPos        <= 1'b0;
            rowMatch      <= 1'b0;
            doneReg       <= 1'b0;
            misCnt        <= '0;
            firstMisValid <= 1'b0;
            firstMisIdx   <= '0;
        end else begin
            rowValid <= 1'b0;
            doneReg  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        maskSop       <= bus.mask_sop;
                        maskPos       <= bus.mask_pos;
                        stopOnMis     <= bus.stop_on_mis;
                        idx           <= '0;
                        misCnt        <= '0;
                        firstMisValid <= 1'b0;
                        firstMisIdx   <= '0;
                        state         <= ST_SWEEP;
                    end
                end
                ST_SWEEP: begin
                    rowValid <= 1'b1;
                    rowIdx   <= idx;
                    rowSop   <= evalSop;
                    rowPos   <= evalPos;
                    rowMatch <= evalMatch;
                    if (!evalMatch) begin
                        if (misCnt != CNT_MAX) begin
                            misCnt <= misCnt + CNT_ONE;
                        end
                        if (!firstMisValid) begin
                            firstMisValid <= 1'b1;
                            firstMisIdx   <= idx;
                        end
                    end
                    idx <= idx + IDX_ONE;
                    // The wrapped idx after the last row is never evaluated.
                    if ((idx == LAST_IDX) || (stopOnMis && !evalMatch)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    doneReg <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy            = (state == ST_SWEEP);
    assign bus.row_valid       = rowValid;
    assign bus.row_idx         = rowIdx;
    assign bus.row_sop         = rowSop;
    assign bus.row_pos         = rowPos;
    assign bus.row_match       = rowMatch;
    assign bus.done            = doneReg;
    assign bus.mis_cnt         = misCnt;
    assign bus.first_mis_valid = firstMisValid;
    assign bus.first_mis_idx   = firstMisIdx;

endmodule
